square_checker: RTL and testbench
=================================

# square_checker

Iterative squarer that closes the loop around `square_root_finder`. It takes the 32-bit Q16.16 root that block produces, squares it by 32-cycle shift-add, and returns the full Q32.32 square plus a saturated 16-bit integer estimate. The self-check path compares that estimate against the original 16-bit `in`.

## Interface
Parameters: none; all widths are fixed.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `root`  in  32  Q16.16 unsigned operand; sampled on the accepting edge.
- `busy`  out  1  high from the accepting edge until the result edge.
- `done`  out  1  one-cycle pulse; `sq`, `sq_int` and `ovf` are valid from this edge.
- `sq`  out  64  Q32.32 unsigned square, root×root, exact.
- `sq_int`  out  16  integer part of `sq`, saturated.
- `ovf`  out  1  high when the integer part of `sq` exceeds 16'hFFFF.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when `start`=1.
  - RUN→DONE after 32 iterations.
  - DONE→IDLE unconditionally.
- Accepting edge, in IDLE with `start`=1:
  - latch `root` into multiplicand and multiplier registers;
  - clear the 64-bit accumulator;
  - clear the 5-bit iteration counter;
  - set `busy`=1.
- RUN, one iteration per cycle, multiplier processed LSB first:
  - if multiplier[0]=1, add the multiplicand to the accumulator;
  - shift the multiplicand left by 1 (64-bit);
  - shift the multiplier right by 1;
  - increment the counter; when the counter is 31, go to DONE.
- DONE:
  - `sq` ← accumulator;
  - `sq_int` and `ovf` from the saturation rule below;
  - `done`=1, `busy`=0.
- Arithmetic:
  - all unsigned; no sign handling;
  - 64-bit accumulator, cannot overflow since (2^32−1)^2 < 2^64;
  - `ovf` = |sq[63:48];
  - `sq_int` = `ovf` ? 16'hFFFF : rounded-or-truncated integer part (see Configuration).
- `start` asserted while `busy`=1 or in DONE is ignored. No queueing.
- `root` changes after the accepting edge have no effect.
- Outputs `sq`, `sq_int` and `ovf` hold their value until the next DONE.
- Reset (async, `rst`=0, at any time, including mid-RUN):
  - state IDLE;
  - `busy`=0, `done`=0, `ovf`=0;
  - `sq`=64'h0, `sq_int`=16'h0;
  - internal registers cleared.
  - An operation aborted by reset produces no `done`.

## Timing
- Accepting edge N: `busy` rises after edge N.
- Iterations occur on edges N+1 … N+32.
- DONE is the state during cycle N+32 → N+33.
- Edge N+33: `done`=1 and outputs updated; `busy`=0.
- Edge N+34: `done`=0; `start` can be accepted here at the earliest (back-to-back period is 34 cycles).
- Latency: 33 cycles from the accepting edge to `done`.
- All outputs are registered. No combinational path from input to output.
- Sized to close at the 21.6 ns clock used by the square-root datapath.

## Configuration
- Macro: `SQ_CHECK_ROUND_EN`.
- Defined:
  - `sq_int` = sq[47:32] + sq[31] (round half-up);
  - if the +1 carries past 16'hFFFF, saturate to 16'hFFFF and set `ovf`=1.
- Undefined:
  - `sq_int` = sq[47:32] (truncation);
  - `ovf` depends only on sq[63:48].
- `sq`, latency and handshake are identical in both builds.

## Test plan
- Reset mid-RUN:
  - stimulus: start with root=32'h0001_BB67, assert `rst`=0 at edge N+10;
  - response: outputs and state are at their reset values, no `done` occurs, and a new start afterwards completes normally.
- Nominal √3:
  - stimulus: root=32'h0001_BB67;
  - response: `done` at N+33 and sq=64'h0000_0002_FFFD_A371;
  - `sq_int`=3 with `SQ_CHECK_ROUND_EN`, 2 without; ovf=0.
- Exact value:
  - stimulus: root=32'h0002_0000;
  - response: sq=64'h0000_0004_0000_0000, sq_int=4, ovf=0.
- Overflow:
  - stimulus: root=32'h0100_0000;
  - response: sq=64'h0001_0000_0000_0000, ovf=1, sq_int=16'hFFFF.
- Maximum operand:
  - stimulus: root=32'hFFFF_FFFF;
  - response: sq=64'hFFFF_FFFE_0000_0001, ovf=1, sq_int=16'hFFFF.
- Handshake:
  - stimulus: `start` held high for 40 cycles with root=32'h0003_0000;
  - response: exactly one accept at N, `done` at N+33 with sq=64'h0000_0009_0000_0000, second accept at N+34;
  - a `root` change at N+5 is ignored.

Source files
------------

// File: rtl/square_checker.sv
// rtl/square_checker.sv - 32-cycle shift-add squarer for Q16.16 roots, Q32.32 result plus saturated integer estimate.
// Optional round-half-up of the integer estimate under `SQ_CHECK_ROUND_EN.
module square_checker (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] root,
  output logic        busy,
  output logic        done,
  output logic [63:0] sq,
  output logic [15:0] sq_int,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic [15:0] sq_int_nxt;
  logic        ovf_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == 5'd31) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Integer estimate of the finished accumulator, registered on the DONE edge.
`ifdef SQ_CHECK_ROUND_EN
  logic [16:0] rnd;
  always_comb begin
    rnd        = {1'b0, acc[47:32]} + {16'd0, acc[31]};
    ovf_nxt    = (|acc[63:48]) | rnd[16];
    sq_int_nxt = ovf_nxt ? 16'hFFFF : rnd[15:0];
  end
`else
  always_comb begin
    ovf_nxt    = |acc[63:48];
    sq_int_nxt = ovf_nxt ? 16'hFFFF : acc[47:32];
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= 64'd0;
      mplier <= 32'd0;
      acc    <= 64'd0;
      cnt    <= 5'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sq     <= 64'd0;
      sq_int <= 16'd0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= {32'd0, root};
            mplier <= root;
            acc    <= 64'd0;
            cnt    <= 5'd0;
            busy   <= 1'b1;
          end
        end
        S_RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= {mcand[62:0], 1'b0};
          mplier <= {1'b0, mplier[31:1]};
          cnt    <= cnt + 5'd1;
        end
        S_DONE: begin
          sq     <= acc;
          sq_int <= sq_int_nxt;
          ovf    <= ovf_nxt;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_square_checker.sv
// tb/tb_square_checker.sv - directed self-checking bench for square_checker.
module tb_square_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] root;
  logic        busy;
  logic        done;
  logic [63:0] sq;
  logic [15:0] sq_int;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  square_checker dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .root   (root),
    .busy   (busy),
    .done   (done),
    .sq     (sq),
    .sq_int (sq_int),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at #1 after an edge with the DUT idle; returns at #1 after edge N+34.
  task automatic run_op(input string tag, input logic [31:0] r, input logic [63:0] exp_sq,
                        input logic [15:0] exp_int, input logic exp_ovf);
    int k;
    start = 1'b1;
    root  = r;
    @(posedge clk); #1;
    start = 1'b0;
    root  = $urandom;
    check({tag, ".busy_rise"}, 64'(busy), 64'd1);
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, ".latency"}, 64'(k), 64'd33);
    check({tag, ".sq"}, sq, exp_sq);
    check({tag, ".sq_int"}, 64'(sq_int), 64'(exp_int));
    check({tag, ".ovf"}, 64'(ovf), 64'(exp_ovf));
    check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".sq_hold"}, sq, exp_sq);
  endtask

  initial begin
    int k;
    int ndone;
    int accepts;
    int done_at;
    int second_at;
    logic prev_busy;
    logic [15:0] rt3_int;

`ifdef SQ_CHECK_ROUND_EN
    rt3_int = 16'd3;
`else
    rt3_int = 16'd2;
`endif

    rst   = 1'b0;
    start = 1'b0;
    root  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.sq", sq, 64'd0);
    check("reset.sq_int", 64'(sq_int), 64'd0);
    check("reset.ovf", 64'(ovf), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("sqrt3", 32'h0001_BB67, 64'h0000_0002_FFFD_A371, rt3_int, 1'b0);

    // Abort mid-run: reset lands at edge N+10 and must clear the previous result.
    start = 1'b1;
    root  = 32'h0001_BB67;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(posedge clk);
    rst = 1'b0;
    #1;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.sq", sq, 64'd0);
    check("abort.sq_int", 64'(sq_int), 64'd0);
    check("abort.ovf", 64'(ovf), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort.no_done", 64'(ndone), 64'd0);
    check("abort.idle_busy", 64'(busy), 64'd0);

    run_op("restart", 32'h0001_BB67, 64'h0000_0002_FFFD_A371, rt3_int, 1'b0);
    run_op("exact", 32'h0002_0000, 64'h0000_0004_0000_0000, 16'd4, 1'b0);
    run_op("ovf", 32'h0100_0000, 64'h0001_0000_0000_0000, 16'hFFFF, 1'b1);
    run_op("max", 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 16'hFFFF, 1'b1);
    run_op("one", 32'h0001_0000, 64'h0000_0001_0000_0000, 16'd1, 1'b0);
    run_op("half", 32'h0000_8000, 64'h0000_0000_4000_0000, 16'd0, 1'b0);

    // Start held high for 40 edges; root changes before edge N+5.
    start     = 1'b1;
    root      = 32'h0003_0000;
    accepts   = 0;
    done_at   = -1;
    second_at = -1;
    prev_busy = busy;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 4) root = 32'h0001_0000;
      if (busy && !prev_busy) begin
        accepts++;
        if (accepts == 2) second_at = i;
      end
      if (done && done_at < 0) begin
        done_at = i;
        check("hs.sq", sq, 64'h0000_0009_0000_0000);
        check("hs.sq_int", 64'(sq_int), 64'd9);
      end
      prev_busy = busy;
    end
    start = 1'b0;
    check("hs.accept_first", 64'(busy), 64'd1);
    check("hs.done_at", 64'(done_at), 64'd33);
    check("hs.second_at", 64'(second_at), 64'd34);
    check("hs.accepts", 64'(accepts), 64'd2);
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("hs.second_latency", 64'(k), 64'd28);
    check("hs.second_sq", sq, 64'h0000_0001_0000_0000);
    check("hs.second_sq_int", 64'(sq_int), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
